// File: rtl/gpu_vtiming.sv
// Video timing generator with a per-line refill handshake.
// Counts pixels (hc) and lines (vc) and decodes sync, data-enable and
// scaled pixel coordinates. One clock before each displayed source line
// it requests a refill. A missed refill deadline raises a sticky underrun.
module gpu_vtiming #(
    parameter int unsigned CW         = 12,
    parameter int unsigned H_ACT      = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACT      = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned HS_POL     = 0,
    parameter int unsigned VS_POL     = 0,
    parameter int unsigned SCALE_LOG2 = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          line_ack,
    input  logic          underrun_clr,
    output logic [CW-1:0] hc,
    output logic [CW-1:0] vc,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start,
    output logic          line_req,
    output logic [CW-1:0] line_num,
    output logic          underrun
);

    localparam int unsigned HBlank = H_FP + H_SYNC + H_BP;
    localparam int unsigned HTotal = HBlank + H_ACT;
    localparam int unsigned VBlank = V_FP + V_SYNC + V_BP;
    localparam int unsigned VTotal = VBlank + V_ACT;

    localparam logic [CW-1:0] HLast      = CW'(HTotal - 1);
    localparam logic [CW-1:0] VLast      = CW'(VTotal - 1);
    localparam logic [CW-1:0] HBlankC    = CW'(HBlank);
    localparam logic [CW-1:0] VBlankC    = CW'(VBlank);
    // Last blanking pixel: a refill still pending here is too late.
    localparam logic [CW-1:0] HDeadline  = CW'(HBlank - 1);
    localparam logic [CW-1:0] HSyncStart = CW'(H_FP);
    localparam logic [CW-1:0] HSyncEnd   = CW'(H_FP + H_SYNC);
    localparam logic [CW-1:0] VSyncStart = CW'(V_FP);
    localparam logic [CW-1:0] VSyncEnd   = CW'(V_FP + V_SYNC);
    localparam logic [CW-1:0] ScaleMask  = CW'((1 << SCALE_LOG2) - 1);
    localparam logic          HsAct      = (HS_POL != 0);
    localparam logic          VsAct      = (VS_POL != 0);

    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;
    logic [CW-1:0] vn;
    logic [CW-1:0] line_rel;
    logic          req_hit;
    logic          line_req_q, line_req_d;
    logic [CW-1:0] line_num_q, line_num_d;
    logic          underrun_q, underrun_d;
    logic          underrun_set;

    // Counter advance and refill request/deadline next-state logic
    always_comb begin
        hc_d     = (hc_q == HLast) ? '0 : hc_q + 1'b1;
        vn       = (vc_q == VLast) ? '0 : vc_q + 1'b1;
        vc_d     = (hc_q == HLast) ? vn : vc_q;
        line_rel = vn - VBlankC;
        // Only the first replicated copy of a source line needs a refill
        req_hit  = (hc_q == HLast) && (vn >= VBlankC) && ((line_rel & ScaleMask) == '0);

        line_req_d   = line_req_q;
        line_num_d   = line_num_q;
        underrun_set = 1'b0;
        // An ack on the deadline cycle wins over the underrun
        if (line_req_q && line_ack) begin
            line_req_d = 1'b0;
        end else if (line_req_q && (hc_q == HDeadline)) begin
            line_req_d   = 1'b0;
            underrun_set = 1'b1;
        end
        if (req_hit) begin
            line_req_d = 1'b1;
            line_num_d = line_rel >> SCALE_LOG2;
        end

        // A set in the same cycle as a clear leaves underrun high
        underrun_d = underrun_q;
        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q       <= '0;
            vc_q       <= '0;
            line_req_q <= 1'b0;
            line_num_q <= '0;
            underrun_q <= 1'b0;
        end else begin
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            line_req_q <= line_req_d;
            line_num_q <= line_num_d;
            underrun_q <= underrun_d;
        end
    end

    // Timing decode straight from the registered counters
    always_comb begin
        de          = (hc_q >= HBlankC) && (vc_q >= VBlankC);
        hsync       = ((hc_q >= HSyncStart) && (hc_q < HSyncEnd)) ? HsAct : ~HsAct;
        vsync       = ((vc_q >= VSyncStart) && (vc_q < VSyncEnd)) ? VsAct : ~VsAct;
        x           = de ? ((hc_q - HBlankC) >> SCALE_LOG2) : '0;
        y           = de ? ((vc_q - VBlankC) >> SCALE_LOG2) : '0;
        frame_start = (hc_q == '0) && (vc_q == '0) && !reset;
    end

    assign hc       = hc_q;
    assign vc       = vc_q;
    assign line_req = line_req_q;
    assign line_num = line_num_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_gpu_vtiming.sv
// Bench for gpu_vtiming with a tiny 14x7 raster. A counter model predicts
// every cycle's timing outputs through a scoreboard queue. A vector table
// pins key raster points, and hand sequences exercise refill, ack, underrun
// and reset corner cases.
module tb_gpu_vtiming;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int HB = 6;
    localparam int VB = 3;

    logic        clk;
    logic        reset;
    logic        ack0, clr0, ack1, clr1;
    logic [11:0] hc0, vc0, x0, y0, num0;
    logic        de0, hs0, vs0, fs0, req0, ur0;
    logic [11:0] hc1, vc1, x1, y1, num1;
    logic        de1, hs1, vs1, fs1, req1, ur1;

    gpu_vtiming #(
        .CW(12), .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .SCALE_LOG2(0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .line_ack(ack0), .underrun_clr(clr0),
        .hc(hc0), .vc(vc0), .x(x0), .y(y0), .de(de0), .hsync(hs0), .vsync(vs0),
        .frame_start(fs0), .line_req(req0), .line_num(num0), .underrun(ur0)
    );

    gpu_vtiming #(
        .CW(12), .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .SCALE_LOG2(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .line_ack(ack1), .underrun_clr(clr1),
        .hc(hc1), .vc(vc1), .x(x1), .y(y1), .de(de1), .hsync(hs1), .vsync(vs1),
        .frame_start(fs1), .line_req(req1), .line_num(num1), .underrun(ur1)
    );

    typedef struct {
        int hc, vc, de, hs, vs, x, y, fs, x1, y1;
    } exp_t;

    typedef struct {
        int hc, vc, de, hs, vs, x, y, fs, req, ur;
    } vec_t;

    exp_t sb[$];
    vec_t vt[12];
    int   n_pass  = 0;
    int   n_total = 0;
    int   mh = 0;
    int   mv = 0;

    // Request monitor for the scaled instance
    int   rises1 = 0;
    logic prev1  = 1'b0;
    int   nums1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            prev1 <= 1'b0;
        end else begin
            if (req1 && !prev1) begin
                rises1 <= rises1 + 1;
                nums1.push_back(int'(num1));
            end
            prev1 <= req1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (model hc=%0d vc=%0d)",
                      name, act, exp, mh, mv);
    endtask

    // Advance one clock; expectation pushed before the edge, checked after it
    task automatic step();
        int   nh, nv;
        exp_t e, g;
        if (reset) begin
            nh = 0;
            nv = 0;
        end else begin
            nh = (mh == HT - 1) ? 0 : mh + 1;
            nv = (mh == HT - 1) ? ((mv == VT - 1) ? 0 : mv + 1) : mv;
        end
        e.hc = nh;
        e.vc = nv;
        e.de = (nh >= HB && nv >= VB) ? 1 : 0;
        e.hs = (nh >= 2 && nh < 4) ? 0 : 1;
        e.vs = (nv == 1) ? 0 : 1;
        e.x  = e.de ? nh - HB : 0;
        e.y  = e.de ? nv - VB : 0;
        e.fs = (nh == 0 && nv == 0 && !reset) ? 1 : 0;
        e.x1 = e.x >> 1;
        e.y1 = e.y >> 1;
        sb.push_back(e);
        @(posedge clk);
        mh = nh;
        mv = nv;
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            g = sb.pop_front();
            check("hc", int'(hc0), g.hc);
            check("vc", int'(vc0), g.vc);
            check("de", int'(de0), g.de);
            check("hsync", int'(hs0), g.hs);
            check("vsync", int'(vs0), g.vs);
            check("x", int'(x0), g.x);
            check("y", int'(y0), g.y);
            check("frame_start", int'(fs0), g.fs);
            check("x_scaled", int'(x1), g.x1);
            check("y_scaled", int'(y1), g.y1);
        end
    endtask

    task automatic goto(int h, int v);
        int g = 0;
        while (!(mh == h && mv == v) && g < 200) begin
            step();
            g++;
        end
        check("goto_pos", int'(hc0) * 100 + int'(vc0), h * 100 + v);
    endtask

    initial begin
        //            hc vc de hs vs x  y  fs req ur
        vt[0]  = '{0,  0, 0, 1, 1, 0, 0, 1, 0, 0};
        vt[1]  = '{2,  0, 0, 0, 1, 0, 0, 0, 0, 0};
        vt[2]  = '{4,  0, 0, 1, 1, 0, 0, 0, 0, 0};
        vt[3]  = '{5,  1, 0, 1, 0, 0, 0, 0, 0, 0};
        vt[4]  = '{13, 2, 0, 1, 1, 0, 0, 0, 0, 0};
        vt[5]  = '{0,  3, 0, 1, 1, 0, 0, 0, 1, 0};
        vt[6]  = '{5,  3, 0, 1, 1, 0, 0, 0, 1, 0};
        vt[7]  = '{6,  3, 1, 1, 1, 0, 0, 0, 0, 1};
        vt[8]  = '{13, 3, 1, 1, 1, 7, 0, 0, 0, 1};
        vt[9]  = '{0,  4, 0, 1, 1, 0, 0, 0, 1, 1};
        vt[10] = '{9,  6, 1, 1, 1, 3, 3, 0, 0, 1};
        vt[11] = '{13, 6, 1, 1, 1, 7, 3, 0, 0, 1};

        reset = 1'b1;
        ack0  = 1'b0;
        clr0  = 1'b0;
        ack1  = 1'b1;
        clr1  = 1'b0;

        // Reset held for three edges
        @(negedge clk);
        repeat (3) step();
        check("rst_line_req", int'(req0), 0);
        check("rst_underrun", int'(ur0), 0);
        check("rst_line_num", int'(num0), 0);
        reset = 1'b0;
        #1;
        check("release_frame_start", int'(fs0), 1);

        // Frame 1: no acks, table of raster points
        for (int i = 0; i < 12; i++) begin
            goto(vt[i].hc, vt[i].vc);
            check("vec_de", int'(de0), vt[i].de);
            check("vec_hsync", int'(hs0), vt[i].hs);
            check("vec_vsync", int'(vs0), vt[i].vs);
            check("vec_x", int'(x0), vt[i].x);
            check("vec_y", int'(y0), vt[i].y);
            check("vec_frame_start", int'(fs0), vt[i].fs);
            check("vec_line_req", int'(req0), vt[i].req);
            check("vec_underrun", int'(ur0), vt[i].ur);
        end

        // Scaled instance: two requests per frame, lines 0 then 1
        check("scaled_req_count", rises1, 2);
        check("scaled_num_first", (nums1.size() > 0) ? nums1[0] : -1, 0);
        check("scaled_num_second", (nums1.size() > 1) ? nums1[1] : -1, 1);
        check("scaled_underrun", int'(ur1), 0);

        // Sticky underrun persists into frame 2 until a clear pulse
        goto(0, 1);
        check("ur_sticky", int'(ur0), 1);
        check("num_retained", int'(num0), 3);
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        check("ur_cleared", int'(ur0), 0);
        step();
        check("ur_stays_clear", int'(ur0), 0);

        // Refill acked two cycles after the request
        goto(13, 2);
        check("refill_pre", int'(req0), 0);
        step();
        check("refill_req", int'(req0), 1);
        check("refill_num", int'(num0), 0);
        step();
        step();
        check("refill_hold", int'(req0), 1);
        ack0 = 1'b1;
        step();
        ack0 = 1'b0;
        check("refill_acked", int'(req0), 0);
        check("refill_num_kept", int'(num0), 0);
        goto(6, 3);
        check("refill_no_ur", int'(ur0), 0);

        // Stray ack with no request is ignored
        ack0 = 1'b1;
        step();
        ack0 = 1'b0;
        check("stray_ack_req", int'(req0), 0);
        check("stray_ack_ur", int'(ur0), 0);

        // Ack on the deadline cycle wins
        goto(0, 4);
        check("req_line1", int'(req0), 1);
        check("num_line1", int'(num0), 1);
        goto(5, 4);
        ack0 = 1'b1;
        step();
        ack0 = 1'b0;
        check("deadline_ack_req", int'(req0), 0);
        check("deadline_ack_ur", int'(ur0), 0);

        // Set and clear in the same cycle keeps underrun set
        goto(5, 5);
        check("pre_setclr_req", int'(req0), 1);
        check("pre_setclr_num", int'(num0), 2);
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        check("setclr_ur", int'(ur0), 1);
        check("setclr_req", int'(req0), 0);
        goto(10, 5);
        check("num_retained2", int'(num0), 2);
        check("ur_still_set", int'(ur0), 1);

        // Reset with a request pending aborts it without underrun
        goto(3, 6);
        check("pre_rst_req", int'(req0), 1);
        reset = 1'b1;
        step();
        check("midrst_req", int'(req0), 0);
        check("midrst_ur", int'(ur0), 0);
        check("midrst_num", int'(num0), 0);
        reset = 1'b0;
        repeat (20) step();
        check("post_rst_req", int'(req0), 0);
        check("post_rst_ur", int'(ur0), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
